pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
- Program-counter stage that consumes the 13-bit word-aligned branch offset produced by the shift-left-by-one stage.
- Holds the architectural PC and computes PC+2 and the branch target.
- Selects the next PC among sequential, taken-branch and jump sources.
- Sequences a one-cycle flush bubble after every redirect so fetch/decode can squash the wrong-path instruction.

Parameters:
- RESET_VECTOR, 16'h0000, PC value loaded on reset.
- CNT_W, 16, width of the taken-redirect event counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard stall: hold PC and state.
- branch_req  input  1  decode holds a branch this cycle.
- branch_taken  input  1  branch condition true; qualified by branch_req.
- branch_off  input  13  signed byte offset from the shift-left-by-one stage; bit 0 is 0.
- jump_req  input  1  absolute jump this cycle.
- jump_addr  input  16  absolute jump target.
- pc  output  16  current PC (fetch address).
- pc_plus2  output  16  pc + 2, modulo 2^16; combinational from pc.
- flush  output  1  squash the wrong-path instruction in fetch/decode.
- misalign_err  output  1  sticky: a jump target with bit 0 = 1 was accepted.
- redirect_cnt  output  CNT_W  count of accepted redirects.

Behaviour:
- Reset, asynchronous, while rst_n = 0:
  - pc = RESET_VECTOR, state = RUN.
  - flush = 0, misalign_err = 0, redirect_cnt = 0.
  - Reset mid-REDIRECT abandons the bubble immediately.
- Arithmetic:
  - sext = {{3{branch_off[12]}}, branch_off}.
  - br_target = (pc + sext) mod 2^16, with bit 0 forced to 0.
  - jmp_target = {jump_addr[15:1], 1'b0}.
  - pc_plus2 wraps: 16'hFFFE -> 16'h0000.
- State RUN, flush = 0:
  - stall = 1: pc and state hold; requests are ignored and not latched.
  - Else, jump_req = 1 (jump has priority over branch):
    - pc <= jmp_target; state <= REDIRECT; redirect_cnt += 1.
    - If jump_addr[0] = 1, misalign_err <= 1.
  - Else, branch_req & branch_taken:
    - pc <= br_target; state <= REDIRECT; redirect_cnt += 1.
  - Else: pc <= pc_plus2 (a not-taken branch counts as sequential).
- State REDIRECT, flush = 1:
  - flush is a registered Moore output of the state, so it is high exactly in the cycle after the redirect edge.
  - stall = 1: hold REDIRECT and pc; flush stays 1.
  - Else: pc <= pc_plus2; state <= RUN.
  - branch_req and jump_req are ignored; they belong to the squashed instruction.
- Latency: a redirect accepted at edge N makes pc = target after edge N; flush is high for cycle N..N+1.
- redirect_cnt saturates at all-ones; it never wraps.
- misalign_err clears only on reset.
- Zero offset (branch_off = 0) still redirects to the same pc and generates flush; this defines a branch-to-self loop.

Decomposition:
- Shared package (datapath constants):
  - PC_W = 16, OFF_W = 13.
  - State encoding: RUN = 1'b0, REDIRECT = 1'b1.
  - RESET_VECTOR default.
- One natural sub-module: pc_target_adder, combinational.
  - Computes sign extension, br_target and pc_plus2.
  - Keeps all arithmetic out of the FSM/register file.

Test Plan:
- Reset and sequential run:
  - Stimulus: rst_n low for 2 cycles, then release; no requests.
  - Response: pc = 0000, 0002, 0004, ...; flush = 0; redirect_cnt = 0.
  - Reasserting rst_n asynchronously mid-cycle forces pc = 0000 without waiting for a clock edge.
- Taken branch, both signs:
  - Stimulus A: pc = 0010, branch_req = 1, branch_taken = 1, branch_off = 13'h0040.
  - Response A: pc = 0050; flush = 1 for one cycle; then pc = 0052; redirect_cnt = 1.
  - Stimulus B: branch_off = 13'h1FF0 (-16) at pc = 0050.
  - Response B: pc = 0040.
- Not-taken branch and priority:
  - Stimulus: branch_req = 1, branch_taken = 0.
  - Response: pc += 2; no flush.
  - Stimulus: jump_req = 1 with jump_addr = 1234 and a taken branch in the same cycle.
  - Response: pc = 1234.
- Wrap-around:
  - Sequential case: pc = FFFE with no request -> pc = 0000.
  - Branch case: pc = FFF0 with branch_off = 13'h0020 -> pc = 0010.
- Stall interaction:
  - Stimulus: stall = 1 in RUN with a taken branch presented.
  - Response: pc and state unchanged; no redirect.
  - Stimulus: stall = 1 held for 3 cycles in REDIRECT.
  - Response: flush stays 1 for those cycles; requests during REDIRECT are ignored; redirect_cnt is unchanged.
- Misalign and saturation:
  - Stimulus: jump_addr = 0101.
  - Response: pc = 0100; misalign_err = 1 and stays 1 until reset.
  - Stimulus: preload redirect_cnt to FFFF via 65535 redirects (or force), then one more redirect.
  - Response: redirect_cnt stays FFFF.

Source files
------------

// File: rtl/pc_redirect_unit_pkg.sv
// Shared datapath constants and state type for the PC redirect unit.
//   PC_W / OFF_W     : program-counter and branch-offset widths
//   RESET_VECTOR_DEF : default PC value loaded on reset
//   state_t          : RUN (sequential fetch) / REDIRECT (one-cycle flush bubble)
package pc_redirect_unit_pkg;

  localparam int unsigned PC_W  = 16;
  localparam int unsigned OFF_W = 13;

  localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 16'h0000;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_t;

endpackage : pc_redirect_unit_pkg

// File: rtl/pc_redirect_unit_adder.sv
// pc_target_adder: combinational next-PC arithmetic.
//   pc         in  : current PC
//   branch_off in  : signed byte offset, bit 0 always 0
//   br_target  out : pc + sign-extended offset, mod 2^16, bit 0 forced low
//   pc_plus2   out : pc + 2, mod 2^16
module pc_target_adder
  import pc_redirect_unit_pkg::*;
(
  input  logic [PC_W-1:0]  pc,
  input  logic [OFF_W-1:0] branch_off,
  output logic [PC_W-1:0]  br_target,
  output logic [PC_W-1:0]  pc_plus2
);

  logic [PC_W-1:0] sext;

  assign sext      = {{(PC_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};
  // Masking bit 0 keeps the target halfword-aligned even if an odd offset slips in.
  assign br_target = (pc + sext) & {{(PC_W-1){1'b1}}, 1'b0};
  assign pc_plus2  = pc + PC_W'(2);

endmodule : pc_target_adder

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: architectural PC register with branch/jump redirect and a
// one-cycle flush bubble after every accepted redirect.
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   stall              : hold PC and state
//   branch_req/_taken  : conditional branch request; taken qualifies req
//   branch_off         : signed word-aligned offset from the shift stage
//   jump_req/jump_addr : absolute jump (priority over branch)
//   pc, pc_plus2       : fetch address and its sequential successor
//   flush              : high while in the redirect bubble
//   misalign_err       : sticky, set when an odd jump target is accepted
//   redirect_cnt       : saturating count of accepted redirects
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int unsigned     CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_req,
  input  logic             branch_taken,
  input  logic [OFF_W-1:0] branch_off,
  input  logic             jump_req,
  input  logic [PC_W-1:0]  jump_addr,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus2,
  output logic             flush,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jmp_target;
  logic            mis_q;
  logic [CNT_W-1:0] cnt_q;

  pc_target_adder u_adder (
    .pc         (pc_q),
    .branch_off (branch_off),
    .br_target  (br_target),
    .pc_plus2   (pc_plus2)
  );

  assign jmp_target = {jump_addr[PC_W-1:1], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (!stall) begin
      case (state_q)
        RUN: begin
          if (jump_req) begin
            pc_q    <= jmp_target;
            state_q <= REDIRECT;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            if (jump_addr[0]) mis_q <= 1'b1;
          end else if (branch_req && branch_taken) begin
            pc_q    <= br_target;
            state_q <= REDIRECT;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            pc_q <= pc_plus2;
          end
        end
        // Requests seen here belong to the squashed instruction.
        REDIRECT: begin
          pc_q    <= pc_plus2;
          state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign pc           = pc_q;
  assign flush        = (state_q == REDIRECT);
  assign misalign_err = mis_q;
  assign redirect_cnt = cnt_q;

endmodule : pc_redirect_unit

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

  localparam int unsigned TB_CNT_W = 8;
  localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic                clk;
  logic                rst_n;
  logic                stall;
  logic                branch_req;
  logic                branch_taken;
  logic [12:0]         branch_off;
  logic                jump_req;
  logic [15:0]         jump_addr;
  logic [15:0]         pc;
  logic [15:0]         pc_plus2;
  logic                flush;
  logic                misalign_err;
  logic [TB_CNT_W-1:0] redirect_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state (plain arithmetic on ints).
  int m_pc;
  bit m_bubble;
  int m_cnt;
  bit m_mis;

  pc_redirect_unit #(
    .RESET_VECTOR (16'h0000),
    .CNT_W        (TB_CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_req   (branch_req),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .jump_req     (jump_req),
    .jump_addr    (jump_addr),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .flush        (flush),
    .misalign_err (misalign_err),
    .redirect_cnt (redirect_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    32'(pc),           32'(m_pc));
    check({tag, ".pc2"},   32'(pc_plus2),     32'((m_pc + 2) % 65536));
    check({tag, ".flush"}, 32'(flush),        32'(m_bubble));
    check({tag, ".mis"},   32'(misalign_err), 32'(m_mis));
    check({tag, ".cnt"},   32'(redirect_cnt), 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_pc = 0; m_bubble = 0; m_cnt = 0; m_mis = 0;
  endtask

  task automatic model_edge(input bit s, input bit br, input bit tk,
                            input int off, input bit jr, input int ja);
    int soff;
    if (s) return;
    if (m_bubble) begin
      m_pc = (m_pc + 2) % 65536;
      m_bubble = 0;
    end else if (jr) begin
      m_pc = ja - (ja % 2);
      m_bubble = 1;
      if (m_cnt < CNT_MAX) m_cnt++;
      if (ja % 2 == 1) m_mis = 1;
    end else if (br && tk) begin
      soff = (off >= 4096) ? off - 8192 : off;
      m_pc = (m_pc + soff + 65536) % 65536;
      m_pc = m_pc - (m_pc % 2);
      m_bubble = 1;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_pc = (m_pc + 2) % 65536;
    end
  endtask

  // Apply one cycle of inputs, advance the model at the edge, check 1 ns later.
  task automatic step(input string tag, input bit s, input bit br, input bit tk,
                      input int off, input bit jr, input int ja);
    stall = s; branch_req = br; branch_taken = tk;
    branch_off = 13'(off); jump_req = jr; jump_addr = 16'(ja);
    @(posedge clk);
    model_edge(s, br, tk, off, jr, ja);
    #1;
    check_model(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jump(input string tag, input int ja);
    step(tag, 0, 0, 0, 0, 1, ja);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 0; branch_req = 0; branch_taken = 0; branch_off = '0;
    jump_req = 0; jump_addr = '0;
    model_reset();

    // Reset and sequential run
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) idle("seq");
    check("pc_at_0010", 32'(pc), 32'h0010);

    // Taken branch, positive then negative offset
    step("brA", 0, 1, 1, 'h0040, 0, 0);
    check("brA_pc", 32'(pc), 32'h0050);
    check("brA_flush", 32'(flush), 32'h1);
    idle("brA_bubble");
    check("brA_after", 32'(pc), 32'h0052);
    check("brA_cnt", 32'(redirect_cnt), 32'h1);
    step("brB", 0, 1, 1, 'h1FF0, 0, 0);
    check("brB_pc", 32'(pc), 32'h0042);
    idle("brB_bubble");

    // Not-taken branch and jump-over-branch priority
    step("nt", 0, 1, 0, 'h0100, 0, 0);
    step("prio", 0, 1, 1, 'h0040, 1, 'h1234);
    check("prio_pc", 32'(pc), 32'h1234);
    idle("prio_bubble");

    // Stall in RUN with a taken branch presented
    step("stall_run", 1, 1, 1, 'h0040, 0, 0);
    step("stall_run2", 1, 0, 0, 0, 1, 'h4444);
    idle("post_stall");

    // Stall held in REDIRECT with requests that must be ignored
    jump("j2000", 'h2000);
    for (int i = 0; i < 3; i++) step("stall_redir", 1, 1, 1, 'h0040, 1, 'h3333);
    check("stall_redir_flush", 32'(flush), 32'h1);
    step("redir_ignore", 0, 1, 1, 'h0040, 1, 'h5555);
    check("redir_exit_pc", 32'(pc), 32'h2002);

    // Misaligned jump: sticky error
    jump("mis", 'h0101);
    check("mis_pc", 32'(pc), 32'h0100);
    check("mis_flag", 32'(misalign_err), 32'h1);
    idle("mis_bubble");
    idle("mis_hold");

    // Branch-to-self with zero offset
    step("self", 0, 1, 1, 0, 0, 0);
    check("self_flush", 32'(flush), 32'h1);
    idle("self_bubble");

    // Wrap-around: sequential and branch
    jump("wrapj", 'hFFFC);
    idle("wrap_bubble");
    idle("wrap_seq");
    check("wrap_seq_pc", 32'(pc), 32'h0000);
    jump("wrapbj", 'hFFEE);
    idle("wrapb_bubble");
    step("wrap_br", 0, 1, 1, 'h0020, 0, 0);
    check("wrap_br_pc", 32'(pc), 32'h0010);
    idle("wrap_br_bubble");

    // Asynchronous reset mid-cycle, inside a redirect bubble
    jump("pre_areset", 'h0800);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle("after_areset");

    // Counter saturation
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      jump("sat_j", int'($urandom_range(0, 32767)) * 2);
      idle("sat_b");
    end
    check("sat_cnt", 32'(redirect_cnt), 32'(CNT_MAX));

    // Randomized traffic against the model
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("rand_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 500; i++) begin
      step("rand",
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 4095)) * 2,
           $urandom_range(0, 5) == 0,
           int'($urandom_range(0, 65535)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pc_redirect_unit
